wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 alu_valid  in  1  ALU result offered.
REQ-005 alu_ready  out  1  ALU result accepted when alu_valid && alu_ready at clk edge.
REQ-006 alu_rd  in  5  ALU destination register.
REQ-007 alu_data  in  32  ALU result.
REQ-008 ld_valid  in  1  load response present; no backpressure, must be taken that cycle.
REQ-009 ld_rd  in  5  load destination register.
REQ-010 ld_funct3  in  3  load type (LB/LH/LW/LBU/LHU encodings).
REQ-011 ld_addr_lo  in  2  load address bits [1:0].
REQ-012 ld_rdata  in  32  raw aligned memory word.
REQ-013 wEn  out  1  register-file write enable, registered.
REQ-014 rd  out  5  register-file write index, registered.
REQ-015 write_data  out  32  register-file write data, registered.
REQ-016 skid_valid  out  1  ALU result parked in skid buffer; hazard-unit visibility.
REQ-017 skid_rd  out  5  destination of parked ALU result.
REQ-018 ld_err  out  1  one-cycle pulse, registered, for illegal ld_funct3.

Function
REQ-019 Output latency SHALL be exactly one cycle from selection to wEn/rd/write_data.
REQ-020 Per-cycle source priority SHALL be: load, then skid entry, then new ALU handshake.
REQ-021 alu_ready SHALL equal !skid_valid (combinational from state only).
REQ-022 ALU accepted while ld_valid high SHALL be parked in skid (skid_valid=1 next cycle).
REQ-023 Skid entry SHALL retire in the first cycle with ld_valid low; skid_valid clears the same edge.
REQ-024 Skid full and ld_valid high: skid holds, no ALU accepted, no data lost.
REQ-025 Selected destination 0 SHALL produce wEn=0, rd=0, write_data=0 (x0 never written).
REQ-026 No source selected SHALL produce wEn=0, rd and write_data held at previous values.
REQ-027 LB/LBU SHALL select byte ld_addr_lo of ld_rdata, sign-/zero-extended to 32 bits.
REQ-028 LH/LHU SHALL select halfword ld_addr_lo[1], sign-/zero-extended; ld_addr_lo[0] ignored.
REQ-029 LW SHALL pass ld_rdata unchanged; ld_addr_lo ignored.
REQ-030 Illegal funct3 (011,110,111) SHALL write ld_rdata as LW and pulse ld_err next cycle.
REQ-031 Back-to-back loads SHALL retire one per cycle indefinitely; skid waits throughout.

Reset
REQ-032 rst low SHALL immediately force wEn=0, rd=0, write_data=0, skid_valid=0, skid_rd=0, ld_err=0.
REQ-033 alu_ready SHALL read 1 during and after reset; skid contents discarded on reset mid-operation.
REQ-034 Deassertion SHALL be accepted at any edge; first write possible the cycle after deassertion.

Configuration
REQ-035 Macro WB_TRACE_EN defined: each edge with wEn=1 SHALL $display "wb x<rd> = <write_data hex>".
REQ-036 WB_TRACE_EN undefined: no display statements compiled; ports and timing identical.

Structure
REQ-037 Load funct3 encodings and XLEN=32 constant SHALL live in the shared rv_defs package/header.
REQ-038 Load extraction SHALL be one combinational sub-module, load_align.
REQ-039 Whole file SHALL be guarded `ifndef WB_STAGE_V like other stages.

Verification
REQ-040 ALU only: alu_rd=5, alu_data=0x1234 -> next cycle wEn=1, rd=5, write_data=0x00001234.
REQ-041 Collision: ld_valid LW rd=3 0xDEADBEEF with ALU rd=4 0x11 same cycle -> cycle+1 x3=0xDEADBEEF, skid_valid=1, alu_ready=0; cycle+2 x4=0x11.
REQ-042 LB addr_lo=2 rdata=0x0080FF00 -> 0xFFFFFF80; LBU -> 0x00000080; LHU addr_lo=2 -> 0x00000080; LH addr_lo=0 -> 0xFFFFFF00.
REQ-043 ALU rd=0 data=0xFFFFFFFF -> wEn=0, write_data=0; funct3=011 -> LW data and ld_err pulse of one cycle.
REQ-044 Skid full, rst low mid-stream -> all outputs 0 asynchronously, alu_ready=1, parked result never written.
REQ-045 Four consecutive loads with skid pending -> four load writes in order, then skid write on fifth cycle.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared RV32 constants (XLEN, load funct3 encodings) for the pipeline stages.
package wb_stage_pkg;
   localparam int XLEN = 32;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: extracts and extends the addressed byte/halfword from an aligned load word.
module load_align
   import wb_stage_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] data,
   output logic            illegal
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b       = rdata[8*addr_lo +: 8];
      h       = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
      // illegal encodings fall through to the full word
      data    = funct3 == F3_LB  ? {{24{b[7]}}, b} :
                funct3 == F3_LBU ? {24'b0, b} :
                funct3 == F3_LH  ? {{16{h[15]}}, h} :
                funct3 == F3_LHU ? {16'b0, h} : rdata;
   end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback arbiter for loads and ALU results with a one-entry ALU skid buffer.
// Defining WB_TRACE_EN prints a line for every register-file write.
`ifndef WB_STAGE_V
`define WB_STAGE_V
module wb_stage
   import wb_stage_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_valid,
   input  logic [4:0]      ld_rd,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_addr_lo,
   input  logic [XLEN-1:0] ld_rdata,
   output logic            wEn,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] write_data,
   output logic            skid_valid,
   output logic [4:0]      skid_rd,
   output logic            ld_err
);
   logic [XLEN-1:0] ld_data, skid_data, sel_data;
   logic [4:0]      sel_rd;
   logic            ld_illegal, alu_fire, sel;
   load_align u_align (
      .funct3 (ld_funct3),
      .addr_lo(ld_addr_lo),
      .rdata  (ld_rdata),
      .data   (ld_data),
      .illegal(ld_illegal)
   );
   assign alu_ready = !skid_valid;
   always_comb begin
      alu_fire = alu_valid && alu_ready;
      sel      = ld_valid || skid_valid || alu_fire;
      sel_rd   = ld_valid ? ld_rd : skid_valid ? skid_rd : alu_rd;
      sel_data = ld_valid ? ld_data : skid_valid ? skid_data : alu_data;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wEn        <= 1'b0;
         rd         <= '0;
         write_data <= '0;
         skid_valid <= 1'b0;
         skid_rd    <= '0;
         skid_data  <= '0;
         ld_err     <= 1'b0;
      end else begin
         // an ALU result accepted under a load is parked; the skid drains on the first load-free cycle
         if (ld_valid && alu_fire) begin
            skid_valid <= 1'b1;
            skid_rd    <= alu_rd;
            skid_data  <= alu_data;
         end else if (!ld_valid) begin
            skid_valid <= 1'b0;
         end
         wEn    <= sel && sel_rd != '0;
         ld_err <= ld_valid && ld_illegal;
         if (sel) begin
            rd         <= sel_rd;
            write_data <= sel_rd != '0 ? sel_data : '0;
         end
      end
   end
`ifdef WB_TRACE_EN
   always @(posedge clk)
      if (wEn) $display("wb x%0d = %08h", rd, write_data);
`else
`endif
endmodule
`endif

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vector table plus hand sequences for skid, hold and reset behaviour of wb_stage.
module tb_wb_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        alu_valid = 1'b0;
   logic        alu_ready;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_data = '0;
   logic        ld_valid = 1'b0;
   logic [4:0]  ld_rd = '0;
   logic [2:0]  ld_funct3 = '0;
   logic [1:0]  ld_addr_lo = '0;
   logic [31:0] ld_rdata = '0;
   logic        wEn;
   logic [4:0]  rd;
   logic [31:0] write_data;
   logic        skid_valid;
   logic [4:0]  skid_rd;
   logic        ld_err;
   int          total = 0;
   int          passed = 0;

   wb_stage dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo), .ld_rdata(ld_rdata),
      .wEn(wEn), .rd(rd), .write_data(write_data),
      .skid_valid(skid_valid), .skid_rd(skid_rd), .ld_err(ld_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        lv;
      logic [4:0]  lrd;
      logic [2:0]  f3;
      logic [1:0]  lo;
      logic [31:0] rdata;
      logic        av;
      logic [4:0]  ard;
      logic [31:0] adata;
      logic        e_wen;
      logic [4:0]  e_rd;
      logic [31:0] e_data;
      logic        e_err;
   } vec_t;
   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %08h expected %08h", name, act, exp);
      else passed++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ld_valid  = 1'b0;
      alu_valid = 1'b0;
   endtask

   task automatic set_ld(input logic [4:0] r, input logic [2:0] f, input logic [1:0] lo, input logic [31:0] d);
      ld_valid = 1'b1; ld_rd = r; ld_funct3 = f; ld_addr_lo = lo; ld_rdata = d;
   endtask

   task automatic set_alu(input logic [4:0] r, input logic [31:0] d);
      alu_valid = 1'b1; alu_rd = r; alu_data = d;
   endtask

   task automatic chk_wr(input string name, input logic w, input logic [4:0] r, input logic [31:0] d);
      chk({name, ".wEn"}, 32'(wEn), 32'(w));
      chk({name, ".rd"}, 32'(rd), 32'(r));
      chk({name, ".data"}, write_data, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{0, 0, 3'b000, 0, 0, 1, 5, 32'h00001234, 1, 5, 32'h00001234, 0};
      vecs[1]  = '{1, 1, 3'b000, 2, 32'h0080FF00, 0, 0, 0, 1, 1, 32'hFFFFFF80, 0};
      vecs[2]  = '{1, 2, 3'b100, 2, 32'h0080FF00, 0, 0, 0, 1, 2, 32'h00000080, 0};
      vecs[3]  = '{1, 3, 3'b101, 2, 32'h0080FF00, 0, 0, 0, 1, 3, 32'h00000080, 0};
      vecs[4]  = '{1, 4, 3'b001, 0, 32'h0080FF00, 0, 0, 0, 1, 4, 32'hFFFFFF00, 0};
      vecs[5]  = '{1, 6, 3'b001, 1, 32'h12348765, 0, 0, 0, 1, 6, 32'hFFFF8765, 0};
      vecs[6]  = '{1, 7, 3'b010, 3, 32'hCAFEBABE, 0, 0, 0, 1, 7, 32'hCAFEBABE, 0};
      vecs[7]  = '{1, 8, 3'b000, 3, 32'h7F000000, 0, 0, 0, 1, 8, 32'h0000007F, 0};
      vecs[8]  = '{1, 9, 3'b100, 1, 32'h0000AB00, 0, 0, 0, 1, 9, 32'h000000AB, 0};
      vecs[9]  = '{0, 0, 3'b000, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 32'h00000000, 0};
      vecs[10] = '{1, 10, 3'b011, 1, 32'h55AA55AA, 0, 0, 0, 1, 10, 32'h55AA55AA, 1};
      vecs[11] = '{1, 11, 3'b110, 2, 32'h00000001, 0, 0, 0, 1, 11, 32'h00000001, 1};
      vecs[12] = '{1, 12, 3'b111, 3, 32'h87654321, 0, 0, 0, 1, 12, 32'h87654321, 1};
      vecs[13] = '{1, 0, 3'b010, 0, 32'h13572468, 0, 0, 0, 0, 0, 32'h00000000, 0};
      vecs[14] = '{1, 13, 3'b101, 3, 32'hBEEF1234, 0, 0, 0, 1, 13, 32'h0000BEEF, 0};

      // reset state before any clock edge, and across edges with reset held
      #1;
      chk_wr("rst0", 1'b0, 5'd0, 32'h0);
      chk("rst0.skid_valid", 32'(skid_valid), 0);
      chk("rst0.alu_ready", 32'(alu_ready), 1);
      set_alu(5'd9, 32'h99);
      step();
      chk("rst1.wEn", 32'(wEn), 0);
      chk("rst1.ld_err", 32'(ld_err), 0);
      idle();
      #2 rst = 1'b1;

      foreach (vecs[i]) begin
         ld_valid = vecs[i].lv; ld_rd = vecs[i].lrd; ld_funct3 = vecs[i].f3;
         ld_addr_lo = vecs[i].lo; ld_rdata = vecs[i].rdata;
         alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adata;
         step();
         chk_wr($sformatf("vec%0d", i), vecs[i].e_wen, vecs[i].e_rd, vecs[i].e_data);
         chk($sformatf("vec%0d.ld_err", i), 32'(ld_err), 32'(vecs[i].e_err));
         chk($sformatf("vec%0d.skid_valid", i), 32'(skid_valid), 0);
      end

      // idle cycle: wEn low, rd/data hold last written values
      idle();
      step();
      chk_wr("hold", 1'b0, 5'd13, 32'h0000BEEF);

      // illegal funct3 error is a single-cycle pulse
      set_ld(5'd14, 3'b011, 2'd0, 32'hA5A5A5A5);
      step();
      chk("err.pulse", 32'(ld_err), 1);
      idle();
      step();
      chk("err.clear", 32'(ld_err), 0);

      // collision: load wins, ALU parked then retired next cycle
      set_ld(5'd3, 3'b010, 2'd0, 32'hDEADBEEF);
      set_alu(5'd4, 32'h11);
      step();
      idle();
      chk_wr("col1", 1'b1, 5'd3, 32'hDEADBEEF);
      chk("col1.skid_valid", 32'(skid_valid), 1);
      chk("col1.skid_rd", 32'(skid_rd), 4);
      chk("col1.alu_ready", 32'(alu_ready), 0);
      step();
      chk_wr("col2", 1'b1, 5'd4, 32'h11);
      chk("col2.skid_valid", 32'(skid_valid), 0);
      chk("col2.alu_ready", 32'(alu_ready), 1);

      // four loads behind a pending skid entry; a waiting ALU result is not taken until the skid drains
      set_ld(5'd1, 3'b010, 2'd0, 32'hA1);
      set_alu(5'd20, 32'h2020);
      step();
      chk_wr("b2b0", 1'b1, 5'd1, 32'hA1);
      set_alu(5'd30, 32'h3030);
      for (int k = 0; k < 4; k++) begin
         set_ld(5'(21 + k), 3'b010, 2'd0, 32'(8'h21 + k));
         step();
         chk_wr($sformatf("b2b%0d", k + 1), 1'b1, 5'(21 + k), 32'(8'h21 + k));
         chk($sformatf("b2b%0d.skid_valid", k + 1), 32'(skid_valid), 1);
         chk($sformatf("b2b%0d.skid_rd", k + 1), 32'(skid_rd), 20);
         chk($sformatf("b2b%0d.alu_ready", k + 1), 32'(alu_ready), 0);
      end
      ld_valid = 1'b0;
      step();
      chk_wr("b2b.skid", 1'b1, 5'd20, 32'h2020);
      chk("b2b.skid_clear", 32'(skid_valid), 0);
      step();
      chk_wr("b2b.alu", 1'b1, 5'd30, 32'h3030);
      idle();
      step();
      chk("b2b.idle", 32'(wEn), 0);

      // asynchronous reset with skid full discards the parked result
      set_ld(5'd5, 3'b010, 2'd0, 32'h55);
      set_alu(5'd17, 32'h1717);
      step();
      idle();
      chk("ar.skid_full", 32'(skid_valid), 1);
      #2 rst = 1'b0;
      #1;
      chk_wr("ar.async", 1'b0, 5'd0, 32'h0);
      chk("ar.skid_valid", 32'(skid_valid), 0);
      chk("ar.skid_rd", 32'(skid_rd), 0);
      chk("ar.ld_err", 32'(ld_err), 0);
      chk("ar.alu_ready", 32'(alu_ready), 1);
      step();
      rst = 1'b1;
      step();
      chk("ar.no_park_wr1", 32'(wEn), 0);
      step();
      chk("ar.no_park_wr2", 32'(wEn), 0);
      set_alu(5'd2, 32'h7);
      step();
      idle();
      chk_wr("ar.first_wr", 1'b1, 5'd2, 32'h7);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
